des_key_schedule: RTL and testbench

//  Sequential DES/TDEA key-schedule generator. Accepts one 64-bit key and applies PC-1.

---
 rtl/des_key_schedule.sv | 192 +++++++++++++++++++
 tb/tb_des_key_schedule.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Sequential DES/TDEA key schedule: PC-1 on key accept, then one PC-2 subkey per
// sk_valid/sk_ready handshake in encrypt or decrypt order. Optional macro KEY_PARITY_CHK_EN.
module des_key_schedule #(
    parameter int ROUNDS         = 16,
    parameter int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic        key_abort,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        parity_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Tables use 1-based DES bit numbers; DES bit n of a w-bit vector is vec[w-n].
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic int sum_shifts();
        int s = 0;
        for (int i = 0; i < ROUNDS; i++) s += SHIFT_TBL[i];
        return s % 28;
    endfunction

    // Rotation that takes C0/D0 straight to Cn/Dn so decryption starts at Kn.
    localparam logic [4:0] DEC_INIT_SHIFT = 5'(sum_shifts());

    function automatic logic [4:0] shift_at(input logic [4:0] idx);
        logic [4:0] amt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (idx == 5'(i)) amt = 5'(SHIFT_TBL[i]);
        end
        return amt;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} << n;
        return t[55:28];
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [4:0] n);
        logic [55:0] t;
        t = {x, x} >> n;
        return t[27:0];
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_TBL[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TBL[i]];
        return o;
    endfunction

    logic [0:0]  state_q, state_d;
    logic        init_q;
    logic        dec_q, dec_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        perr_d;
    logic        accept;
    logic        handshake;
    logic [55:0] pc1_key;
    logic [4:0]  first_amt;
    logic [4:0]  enc_amt;
    logic [4:0]  dec_amt;
    logic        key_ok;

    assign key_ready = (state_q == IDLE) && init_q;
    assign sk_valid  = (state_q == RUN);
    assign sk_round  = round_q;
    assign sk_last   = sk_valid && (round_q == 4'(ROUNDS - 1));
    assign subkey    = pc2({c_q, d_q});

    assign accept    = key_valid && key_ready && !key_abort;
    assign handshake = sk_valid && sk_ready;
    assign pc1_key   = pc1(key);
    assign first_amt = decrypt ? DEC_INIT_SHIFT : shift_at(5'd0);
    assign enc_amt   = shift_at({1'b0, round_q} + 5'd1);
    assign dec_amt   = shift_at(5'(ROUNDS - 1) - {1'b0, round_q});

`ifdef KEY_PARITY_CHK_EN
    logic perr_q;

    function automatic logic odd_parity_ok(input logic [63:0] k);
        logic ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (^k[8*b +: 8] == 1'b0) ok = 1'b0;
        end
        return ok;
    endfunction

    assign key_ok     = odd_parity_ok(key);
    assign parity_err = perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end
`else
    // PC-1 discards the parity bits, so they are deliberately left unread here.
    logic parity_bits_unused;
    assign parity_bits_unused = ^{key[56], key[48], key[40], key[32],
                                  key[24], key[16], key[8], key[0], perr_d};
    assign key_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path infers a latch.
        state_d = state_q;
        dec_d   = dec_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        perr_d  = 1'b0;

        if (key_abort) begin
            state_d = IDLE;
            round_d = 4'd0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                if (!key_ok) begin
                    perr_d = 1'b1;
                end else begin
                    c_d     = rotl28(pc1_key[55:28], first_amt);
                    d_d     = rotl28(pc1_key[27:0], first_amt);
                    dec_d   = decrypt;
                    round_d = 4'd0;
                    state_d = RUN;
                end
            end
        end else if (handshake) begin
            if (sk_last) begin
                state_d = IDLE;
                round_d = 4'd0;
            end else begin
                // Decrypt walks back from Cn by undoing the shift that produced the current round.
                c_d     = dec_q ? rotr28(c_q, dec_amt) : rotl28(c_q, enc_amt);
                d_d     = dec_q ? rotr28(d_q, dec_amt) : rotl28(d_q, enc_amt);
                round_d = round_q + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the combinational block above uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
            dec_q   <= 1'b0;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            dec_q   <= dec_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 0x133457799BBCDFF1 key schedule;
// extra ROUNDS=2 and ROUNDS=1 instances cover reduced-round builds.
module tb_des_key_schedule;

    localparam logic [63:0] K_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] K_BAD  = 64'h133457799BBCDFF0;

    logic [47:0] kexp [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid, key_ready, decrypt, key_abort;
    logic [63:0] key;
    logic        sk_valid, sk_ready, sk_last, parity_err;
    logic [47:0] subkey;
    logic [3:0]  sk_round;

    logic        r_valid, r_dec, r_ready;
    logic [63:0] r_key;
    logic        r2_key_ready, r2_valid, r2_last, r2_perr;
    logic [47:0] r2_subkey;
    logic [3:0]  r2_round;
    logic        r1_key_ready, r1_valid, r1_last, r1_perr;
    logic [47:0] r1_subkey;
    logic [3:0]  r1_round;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
        .key(key), .decrypt(decrypt), .key_abort(key_abort), .sk_valid(sk_valid),
        .sk_ready(sk_ready), .subkey(subkey), .sk_round(sk_round), .sk_last(sk_last),
        .parity_err(parity_err)
    );

    des_key_schedule #(.ROUNDS(2)) dut_r2 (
        .clk(clk), .rst_n(rst_n), .key_valid(r_valid), .key_ready(r2_key_ready),
        .key(r_key), .decrypt(r_dec), .key_abort(1'b0), .sk_valid(r2_valid),
        .sk_ready(r_ready), .subkey(r2_subkey), .sk_round(r2_round), .sk_last(r2_last),
        .parity_err(r2_perr)
    );

    des_key_schedule #(.ROUNDS(1)) dut_r1 (
        .clk(clk), .rst_n(rst_n), .key_valid(r_valid), .key_ready(r1_key_ready),
        .key(r_key), .decrypt(r_dec), .key_abort(1'b0), .sk_valid(r1_valid),
        .sk_ready(r_ready), .subkey(r1_subkey), .sk_round(r1_round), .sk_last(r1_last),
        .parity_err(r1_perr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_key(input logic [63:0] k, input logic dec);
        int w = 0;
        while (!key_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("key_ready_before_send", key_ready, 1);
        key_valid = 1'b1;
        key       = k;
        decrypt   = dec;
        @(negedge clk);
        key_valid = 1'b0;
        key       = ~k;
        decrypt   = ~dec;
    endtask

    // Checks every presented subkey against the model until stop_at handshakes are done.
    task automatic collect(input logic dec, input bit rand_rdy, input int stop_at);
        int got = 0;
        int cyc = 0;
        while (got < stop_at && cyc < 400) begin
            sk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            check("sk_valid", sk_valid, 1);
            check("subkey", subkey, dec ? kexp[15-got] : kexp[got]);
            check("sk_round", sk_round, got);
            check("sk_last", sk_last, got == 15);
            if (sk_ready) got++;
            @(negedge clk);
            cyc++;
        end
        sk_ready = 1'b1;
        check("handshake_count", got, stop_at);
        if (stop_at == 16) begin
            check("idle_sk_valid", sk_valid, 0);
            check("idle_key_ready", key_ready, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key = 64'd0; decrypt = 1'b0;
        key_abort = 1'b0; sk_ready = 1'b1;
        r_valid = 1'b0; r_dec = 1'b0; r_ready = 1'b1; r_key = 64'd0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_sk_valid", sk_valid, 0);
        check("rst_sk_round", sk_round, 0);
        check("rst_subkey", subkey, 0);
        check("rst_sk_last", sk_last, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_key_ready", key_ready, 0);
        rst_n = 1'b1;
        check("key_ready_at_release", key_ready, 0);
        @(negedge clk);
        check("key_ready_after_edge", key_ready, 1);

        // Encrypt order, decrypt order, encrypt with random backpressure
        send_key(K_GOOD, 1'b0);
        collect(1'b0, 1'b0, 16);
        send_key(K_GOOD, 1'b1);
        collect(1'b1, 1'b0, 16);
        send_key(K_GOOD, 1'b0);
        collect(1'b0, 1'b1, 16);

        // Abort at round 7 with a competing key offer
        send_key(K_GOOD, 1'b0);
        collect(1'b0, 1'b0, 7);
        check("pre_abort_round", sk_round, 7);
        key_abort = 1'b1;
        key_valid = 1'b1;
        key       = K_GOOD;
        @(negedge clk);
        key_abort = 1'b0;
        key_valid = 1'b0;
        check("abort_sk_valid", sk_valid, 0);
        check("abort_sk_round", sk_round, 0);
        check("abort_key_ready", key_ready, 1);
        @(negedge clk);
        check("abort_key_not_taken", sk_valid, 0);

        // Reset pulse at round 3 of a second key
        send_key(K_GOOD, 1'b1);
        collect(1'b1, 1'b0, 3);
        check("pre_reset_round", sk_round, 3);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_sk_valid", sk_valid, 0);
        check("midrun_rst_sk_round", sk_round, 0);
        check("midrun_rst_subkey", subkey, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_key_ready", key_ready, 1);
        send_key(K_GOOD, 1'b0);
        collect(1'b0, 1'b0, 16);

        // Key with an even-parity byte
`ifdef KEY_PARITY_CHK_EN
        send_key(K_BAD, 1'b0);
        check("parity_err_pulse", parity_err, 1);
        check("parity_sk_valid", sk_valid, 0);
        @(negedge clk);
        check("parity_err_end", parity_err, 0);
        check("parity_sk_valid_2", sk_valid, 0);
        check("parity_key_ready", key_ready, 1);
        send_key(K_GOOD, 1'b0);
        collect(1'b0, 1'b0, 16);
`else
        send_key(K_BAD, 1'b0);
        check("parity_err_tied", parity_err, 0);
        collect(1'b0, 1'b0, 16);
`endif

        // Reduced-round builds: decrypt pass then encrypt pass
        check("r2_key_ready", r2_key_ready, 1);
        check("r1_key_ready", r1_key_ready, 1);
        for (int pass = 0; pass < 2; pass++) begin
            r_valid = 1'b1;
            r_key   = K_GOOD;
            r_dec   = (pass == 0);
            @(negedge clk);
            r_valid = 1'b0;
            check("r2_first", r2_subkey, (pass == 0) ? kexp[1] : kexp[0]);
            check("r2_round0", r2_round, 0);
            check("r2_last0", r2_last, 0);
            check("r1_valid", r1_valid, 1);
            check("r1_subkey", r1_subkey, kexp[0]);
            check("r1_round", r1_round, 0);
            check("r1_last", r1_last, 1);
            @(negedge clk);
            check("r2_second", r2_subkey, (pass == 0) ? kexp[0] : kexp[1]);
            check("r2_round1", r2_round, 1);
            check("r2_last1", r2_last, 1);
            check("r1_done", r1_valid, 0);
            @(negedge clk);
            check("r2_done", r2_valid, 0);
            check("r_perr", {r2_perr, r1_perr}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
